pwr_mnt_scan: RTL and testbench

Multi-channel sequencer for the EG_PHY_PWRMNT power-monitor primitive.
- Drives the primitive's sel_pwr and pwr_mnt_pd inputs and round-robins over the enabled supply channels.
- For each channel it waits a settle time, then debounces the primitive's pwr_dwn_n output.
- Publishes per-channel good/valid status, plus change and fault pulses.
- Sits between the PWRMNT primitive and the system status/interrupt logic. It generalises the single fixed hookup to NUM_CH channels with settle, debounce and timeout timing.

---
 rtl/pwr_mnt_pkg.sv | 56 +++++
 rtl/pwr_mnt_sync.sv | 28 ++
 rtl/pwr_mnt_scan.sv | 169 ++++++++++++++++
 tb/tb_pwr_mnt_scan.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwr_mnt_pkg.sv
// Shared types and helpers for the PWRMNT channel scanner: FSM states, width helpers
// and the round-robin channel search.
package pwr_mnt_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StSettle,
    StSample,
    StNext
  } state_e;

  // Upper bound on the channel count handled by the search helper.
  localparam int unsigned MaxCh = 32;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) w = i + 1;
    end
    return w;
  endfunction

  // Width of a channel index; never zero so a single channel still gets a port.
  function automatic int unsigned sel_width(input int unsigned num_ch);
    return (clog2(num_ch) < 1) ? 1 : clog2(num_ch);
  endfunction

  // Width of a counter that must hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (clog2(max_val + 1) < 1) ? 1 : clog2(max_val + 1);
  endfunction

  // First set mask bit at (incl=1) or after (incl=0) start, wrapping modulo num_ch.
  // Exclusive search ends on start itself, so a lone channel is picked again.
  function automatic int unsigned next_ch(input logic [MaxCh-1:0] mask,
                                          input int unsigned      start,
                                          input int unsigned      num_ch,
                                          input logic             incl);
    int unsigned res;
    int unsigned idx;
    logic        found;
    res   = start;
    found = 1'b0;
    for (int unsigned k = 0; k < MaxCh; k++) begin
      idx = (start + k + {31'd0, ~incl}) % num_ch;
      if (k < num_ch && !found && mask[idx[4:0]]) begin
        found = 1'b1;
        res   = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pwr_mnt_sync.sv
// Two-flop synchroniser for the asynchronous pwr_dwn_n output of the power monitor.
module pwr_mnt_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] ff_q;
  logic [1:0] ff_d;

  always_comb begin
    ff_d = {ff_q[0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_q <= {2{RESET_VAL}};
    end else begin
      ff_q <= ff_d;
    end
  end

  assign q = ff_q[1];

endmodule

// File: rtl/pwr_mnt_scan.sv
// Round-robin sequencer for the PWRMNT primitive: selects each enabled supply channel,
// waits for it to settle, debounces the monitor output and publishes per-channel status.
module pwr_mnt_scan
  import pwr_mnt_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned TIMEOUT    = 64,
  localparam int unsigned SEL_W     = sel_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              pwr_dwn_n,
  output logic [SEL_W-1:0]  sel_pwr,
  output logic              pwr_mnt_pd,
  output logic [NUM_CH-1:0] status,
  output logic [NUM_CH-1:0] status_valid,
  output logic              change_pulse,
  output logic              fault_pulse,
  output logic [SEL_W-1:0]  fault_ch,
  output logic              busy
);

  localparam int unsigned SetW = cnt_width(SETTLE_CYC);
  localparam int unsigned DebW = cnt_width(DEBOUNCE);
  localparam int unsigned ToW  = cnt_width(TIMEOUT);

  logic smp;

  pwr_mnt_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (pwr_dwn_n),
    .q  (smp)
  );

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              pd_q, pd_d;
  logic [SetW-1:0]   settle_q, settle_d;
  logic [DebW-1:0]   deb_q, deb_d;
  logic [ToW-1:0]    to_q, to_d;
  logic              last_q, last_d;
  logic [NUM_CH-1:0] status_q, status_d;
  logic [NUM_CH-1:0] valid_q, valid_d;
  logic              change_q, change_d;
  logic              fault_q, fault_d;
  logic [SEL_W-1:0]  fault_ch_q, fault_ch_d;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    settle_d   = settle_q;
    deb_d      = deb_q;
    to_d       = to_q;
    last_d     = last_q;
    status_d   = status_q;
    valid_d    = valid_q;
    change_d   = 1'b0;
    fault_d    = 1'b0;
    fault_ch_d = fault_ch_q;

    unique case (state_q)
      StIdle: begin
        if (en && |ch_mask) begin
          ptr_d   = SEL_W'(next_ch(MaxCh'(ch_mask), 32'(ptr_q), NUM_CH, 1'b1));
          state_d = StSelect;
        end
      end
      StSelect: begin
        settle_d = SetW'(SETTLE_CYC - 1);
        state_d  = StSettle;
      end
      StSettle: begin
        if (settle_q == '0) begin
          deb_d   = '0;
          to_d    = '0;
          state_d = StSample;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      StSample: begin
        if (smp == last_q) begin
          deb_d = deb_q + 1'b1;
        end else begin
          deb_d  = DebW'(1);
          last_d = smp;
        end
        to_d = to_q + 1'b1;
        // A commit on the same cycle as the timeout takes priority.
        if (deb_d == DebW'(DEBOUNCE)) begin
          status_d[ptr_q] = smp;
          valid_d[ptr_q]  = 1'b1;
          if (valid_q[ptr_q] && (status_q[ptr_q] != smp)) begin
            change_d   = 1'b1;
            fault_ch_d = ptr_q;
          end
          state_d = StNext;
        end else if (to_d == ToW'(TIMEOUT)) begin
          valid_d[ptr_q] = 1'b0;
          fault_d        = 1'b1;
          fault_ch_d     = ptr_q;
          state_d        = StNext;
        end
      end
      StNext: begin
        ptr_d   = SEL_W'(next_ch(MaxCh'(ch_mask), 32'(ptr_q), NUM_CH, 1'b0));
        state_d = (en && |ch_mask) ? StSelect : StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A masked-off channel never reports a valid status, even mid-scan.
    valid_d = valid_d & ch_mask;

    if (state_d == StSelect) sel_d = ptr_d;
    pd_d = !(state_d inside {StSelect, StSettle, StSample});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      sel_q      <= '0;
      pd_q       <= 1'b1;
      settle_q   <= '0;
      deb_q      <= '0;
      to_q       <= '0;
      last_q     <= 1'b0;
      status_q   <= '0;
      valid_q    <= '0;
      change_q   <= 1'b0;
      fault_q    <= 1'b0;
      fault_ch_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      pd_q       <= pd_d;
      settle_q   <= settle_d;
      deb_q      <= deb_d;
      to_q       <= to_d;
      last_q     <= last_d;
      status_q   <= status_d;
      valid_q    <= valid_d;
      change_q   <= change_d;
      fault_q    <= fault_d;
      fault_ch_q <= fault_ch_d;
    end
  end

  assign sel_pwr      = sel_q;
  assign pwr_mnt_pd   = pd_q;
  assign status       = status_q;
  assign status_valid = valid_q;
  assign change_pulse = change_q;
  assign fault_pulse  = fault_q;
  assign fault_ch     = fault_ch_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_pwr_mnt_scan.sv
// Directed bench for pwr_mnt_scan with two channels and short settle/debounce/timeout.
module tb_pwr_mnt_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] ch_mask;
  logic       pwr_dwn_n;
  logic       sel_pwr;
  logic       pwr_mnt_pd;
  logic [1:0] status;
  logic [1:0] status_valid;
  logic       change_pulse;
  logic       fault_pulse;
  logic       fault_ch;
  logic       busy;

  logic ch0_lvl;
  logic ch1_lvl;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Simple model of the primitive: the selected supply's level appears on pwr_dwn_n.
  assign pwr_dwn_n = sel_pwr ? ch1_lvl : ch0_lvl;

  pwr_mnt_scan #(
    .NUM_CH    (2),
    .SETTLE_CYC(4),
    .DEBOUNCE  (3),
    .TIMEOUT   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .ch_mask     (ch_mask),
    .pwr_dwn_n   (pwr_dwn_n),
    .sel_pwr     (sel_pwr),
    .pwr_mnt_pd  (pwr_mnt_pd),
    .status      (status),
    .status_valid(status_valid),
    .change_pulse(change_pulse),
    .fault_pulse (fault_pulse),
    .fault_ch    (fault_ch),
    .busy        (busy)
  );

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; ch_mask = 2'b00; ch0_lvl = 1'b1; ch1_lvl = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pwr_mnt_pd !== 1'b1) begin
      failures++; $display("FAIL reset_pd got=%b exp=1", pwr_mnt_pd);
    end
    checks++;
    if ({sel_pwr, fault_ch, busy} !== 3'b000) begin
      failures++; $display("FAIL reset_sel_fch_busy got=%b exp=000", {sel_pwr, fault_ch, busy});
    end
    checks++;
    if ({status, status_valid} !== 4'b0000) begin
      failures++; $display("FAIL reset_status got=%b exp=0000", {status, status_valid});
    end
    checks++;
    if ({change_pulse, fault_pulse} !== 2'b00) begin
      failures++; $display("FAIL reset_pulses got=%b exp=00", {change_pulse, fault_pulse});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, pwr_mnt_pd} !== 2'b01) begin
      failures++; $display("FAIL idle_after_reset got=%b exp=01", {busy, pwr_mnt_pd});
    end
  endtask

  task automatic test_single();
    int chg;
    chg = 0;
    en = 1'b1; ch_mask = 2'b01;
    @(negedge clk);
    checks++;
    if ({busy, pwr_mnt_pd, sel_pwr} !== 3'b100) begin
      failures++; $display("FAIL single_select got=%b exp=100", {busy, pwr_mnt_pd, sel_pwr});
    end
    repeat (7) begin
      @(negedge clk);
      if (change_pulse) chg++;
    end
    checks++;
    if (status_valid !== 2'b00) begin
      failures++; $display("FAIL single_early_valid got=%b exp=00", status_valid);
    end
    repeat (2) begin
      @(negedge clk);
      if (change_pulse) chg++;
    end
    checks++;
    if ({status[0], status_valid} !== 3'b101) begin
      failures++; $display("FAIL single_commit got=%b exp=101", {status[0], status_valid});
    end
    checks++;
    if (chg != 0) begin
      failures++; $display("FAIL single_no_change got=%0d exp=0", chg);
    end
  endtask

  task automatic test_two_ch();
    int   runs, bad, run, sw;
    logic prev_pd, prev_sel;
    runs = 0; bad = 0; run = 0; sw = 0;
    ch_mask  = 2'b11;
    prev_pd  = pwr_mnt_pd;
    prev_sel = sel_pwr;
    repeat (45) begin
      @(negedge clk);
      if (sel_pwr !== prev_sel) sw++;
      if (pwr_mnt_pd) begin
        run++;
      end else if (prev_pd) begin
        if (run != 1) bad++;
        runs++;
        run = 0;
      end
      prev_pd  = pwr_mnt_pd;
      prev_sel = sel_pwr;
    end
    checks++;
    if (bad != 0 || runs < 4) begin
      failures++; $display("FAIL two_ch_pd_gap bad=%0d runs=%0d exp bad=0 runs>=4", bad, runs);
    end
    checks++;
    if (sw < 4) begin
      failures++; $display("FAIL two_ch_alternate got=%0d exp>=4", sw);
    end
    checks++;
    if ({status, status_valid} !== 4'b0111) begin
      failures++; $display("FAIL two_ch_status got=%b exp=0111", {status, status_valid});
    end
  endtask

  task automatic test_change();
    int   n;
    logic got;
    n = 0; got = 1'b0;
    ch0_lvl = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (change_pulse) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++; $display("FAIL change_timeout got=none exp=pulse within 40 cycles");
    end
    checks++;
    if ({fault_ch, status, status_valid} !== 5'b0_00_11) begin
      failures++; $display("FAIL change_state got=%b exp=00011", {fault_ch, status, status_valid});
    end
    @(negedge clk);
    checks++;
    if (change_pulse !== 1'b0) begin
      failures++; $display("FAIL change_one_cycle got=%b exp=0", change_pulse);
    end
  endtask

  task automatic test_fault();
    int   n;
    logic got, prev_sel;
    n = 0; got = 1'b0; prev_sel = sel_pwr;
    while (!got && n < 40) begin
      @(negedge clk);
      ch1_lvl = ~ch1_lvl;
      n++;
      if (sel_pwr && !prev_sel) got = 1'b1;
      prev_sel = sel_pwr;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (fault_pulse) got = 1'b1;
      ch1_lvl = ~ch1_lvl;
    end
    checks++;
    if (!got || n != 13) begin
      failures++; $display("FAIL fault_latency got=%0d seen=%b exp=13", n, got);
    end
    checks++;
    if ({fault_ch, status, status_valid} !== 5'b1_00_01) begin
      failures++; $display("FAIL fault_state got=%b exp=10001", {fault_ch, status, status_valid});
    end
    ch1_lvl = 1'b0;
    @(negedge clk);
    checks++;
    if ({fault_pulse, sel_pwr, pwr_mnt_pd, busy} !== 4'b0001) begin
      failures++;
      $display("FAIL fault_continue got=%b exp=0001", {fault_pulse, sel_pwr, pwr_mnt_pd, busy});
    end
  endtask

  task automatic test_en_drop();
    int   n, chg;
    logic got, prev_pd;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (status_valid[1]) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++; $display("FAIL ch1_revalid got=%b exp=1", status_valid[1]);
    end
    n = 0; got = 1'b0; prev_pd = pwr_mnt_pd;
    while (!got && n < 30) begin
      @(negedge clk);
      n++;
      if (!pwr_mnt_pd && prev_pd && !sel_pwr) got = 1'b1;
      prev_pd = pwr_mnt_pd;
    end
    ch0_lvl = 1'b1;
    @(negedge clk);
    en = 1'b0;
    n = 0; chg = 0;
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
      if (change_pulse) chg++;
    end
    checks++;
    if (!got || n != 8) begin
      failures++; $display("FAIL en_drop_latency got=%0d exp=8", n);
    end
    checks++;
    if ({busy, pwr_mnt_pd, status, status_valid} !== 6'b01_01_11) begin
      failures++;
      $display("FAIL en_drop_idle got=%b exp=010111", {busy, pwr_mnt_pd, status, status_valid});
    end
    checks++;
    if (chg != 1) begin
      failures++; $display("FAIL en_drop_commit_change got=%0d exp=1", chg);
    end
    ch_mask = 2'b01;
    @(negedge clk);
    checks++;
    if ({status, status_valid} !== 4'b0101) begin
      failures++; $display("FAIL mask_clear_valid got=%b exp=0101", {status, status_valid});
    end
  endtask

  task automatic test_reset_mid();
    ch_mask = 2'b11;
    en = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if ({busy, sel_pwr, pwr_mnt_pd} !== 3'b110) begin
      failures++; $display("FAIL pre_reset_sample got=%b exp=110", {busy, sel_pwr, pwr_mnt_pd});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, sel_pwr, pwr_mnt_pd, fault_ch} !== 4'b0010) begin
      failures++;
      $display("FAIL async_reset_ctrl got=%b exp=0010", {busy, sel_pwr, pwr_mnt_pd, fault_ch});
    end
    checks++;
    if ({status, status_valid, change_pulse, fault_pulse} !== 6'b000000) begin
      failures++;
      $display("FAIL async_reset_status got=%b exp=000000",
               {status, status_valid, change_pulse, fault_pulse});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, sel_pwr, pwr_mnt_pd} !== 3'b100) begin
      failures++; $display("FAIL resume_ch0 got=%b exp=100", {busy, sel_pwr, pwr_mnt_pd});
    end
    repeat (9) @(negedge clk);
    checks++;
    if ({status, status_valid} !== 4'b0101) begin
      failures++; $display("FAIL resume_commit got=%b exp=0101", {status, status_valid});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_ch();
    test_change();
    test_fault();
    test_en_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
